// File: rtl/unit_deploy_ctrl.sv
// Deploy sequencer for player units: card select, mouse-follow, deploy, recycle on death,
// plus the elixir economy that pays for each deployment.
module unit_deploy_ctrl #(
    parameter int NUM_UNITS         = 4,
    parameter int ELIXIR_MAX        = 10,
    parameter int FRAMES_PER_ELIXIR = 60,
    parameter int ELIXIR_INIT       = 5
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   game_over,
    input  logic [NUM_UNITS-1:0]   select_req,
    input  logic                   place_click,
    input  logic                   place_valid,
    input  logic                   cancel,
    input  logic [4*NUM_UNITS-1:0] unit_cost,
    input  logic [NUM_UNITS-1:0]   unit_infield,
    input  logic [NUM_UNITS-1:0]   unit_dead,
    output logic [NUM_UNITS-1:0]   idle_o,
    output logic [NUM_UNITS-1:0]   instate_o,
    output logic [NUM_UNITS-1:0]   deploy_o,
    output logic [3:0]             elixir,
    output logic [1:0]             sel_idx,
    output logic                   busy
);

    localparam logic [3:0] EMAX  = 4'(ELIXIR_MAX);
    localparam logic [3:0] EINIT = 4'(ELIXIR_INIT);
    localparam logic [6:0] FLAST = 7'(FRAMES_PER_ELIXIR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DEPLOY
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic [1:0]             sel_q;
    logic                   dep_tick_q;
    logic [3:0]             elixir_q, elixir_d;
    logic [6:0]             cnt_q, cnt_d;
    logic [NUM_UNITS-1:0]   idle_q, idle_d;
    logic [NUM_UNITS-1:0]   seen_q, seen_d;
    logic [NUM_UNITS-1:0]   dead_prev_q;

    logic                   pick_valid;
    logic [1:0]             pick;
    logic [3:0]             sel_cost;
    logic                   place_fire;
    logic                   inc;
    logic [4:0]             elx_sum;

    // Lowest-index eligible request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (select_req[i] && !unit_infield[i] && !idle_q[i] && !game_over &&
                (elixir_q >= unit_cost[4*i +: 4]) && !pick_valid) begin
                pick_valid = 1'b1;
                pick       = 2'(i);
            end
        end
    end

    always_comb begin
        sel_cost = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel_q == 2'(i)) sel_cost = unit_cost[4*i +: 4];
        end
    end

    // Cancel and game_over both beat a same-cycle placement; the cost guard keeps elixir from underflowing.
    assign place_fire = (state_q == S_ARMED) && !cancel && !game_over && place_click &&
                        place_valid && (elixir_q >= sel_cost);

    assign inc = frame_tick && !game_over && (elixir_q < EMAX) && (cnt_q == FLAST);

    always_comb begin
        cnt_d = cnt_q;
        if (game_over)
            cnt_d = cnt_q;
        else if (elixir_q >= EMAX)
            cnt_d = '0;
        else if (frame_tick)
            cnt_d = (cnt_q == FLAST) ? '0 : cnt_q + 7'd1;

        elx_sum  = {1'b0, elixir_q} - {1'b0, (place_fire ? sel_cost : 4'd0)} + {4'd0, inc};
        elixir_d = (elx_sum > {1'b0, EMAX}) ? EMAX : elx_sum[3:0];
    end

    // seen marks that one frame_tick has already passed with idle high; the next one releases it.
    always_comb begin
        idle_d = idle_q;
        seen_d = seen_q;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (idle_q[i]) begin
                if (frame_tick) begin
                    if (seen_q[i]) idle_d[i] = 1'b0;
                    else           seen_d[i] = 1'b1;
                end
            end else if (unit_dead[i] && !dead_prev_q[i]) begin
                idle_d[i] = 1'b1;
                seen_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            elixir_q    <= EINIT;
            cnt_q       <= '0;
            idle_q      <= '1;
            seen_q      <= '1;
            dead_prev_q <= '0;
        end else begin
            elixir_q    <= elixir_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            seen_q      <= seen_d;
            dead_prev_q <= unit_dead;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            sel_q      <= '0;
            dep_tick_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q <= S_ARMED;
                        sel_q   <= pick;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (cancel || game_over) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (place_fire) begin
                        state_q    <= S_DEPLOY;
                        dep_tick_q <= 1'b0;
                    end
                end
                S_DEPLOY: begin
                    if (frame_tick) begin
                        if (dep_tick_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            dep_tick_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        instate_o = '0;
        deploy_o  = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel_q == 2'(i)) begin
                instate_o[i] = (state_q == S_ARMED);
                deploy_o[i]  = (state_q == S_DEPLOY);
            end
        end
    end

    assign idle_o  = idle_q;
    assign elixir  = elixir_q;
    assign sel_idx = sel_q;
    assign busy    = busy_q;

endmodule

// File: doc/unit_deploy_ctrl.md
Name: unit_deploy_ctrl

Overview:
- Sequences the deployable unit sprites (and/or/nerd gate units): card selection, mouse-follow placement, deploy, and recycle after death.
- Runs the elixir economy: accumulates elixir over time and charges a cost per deployment.
- Drives each unit's idle, instate and deploy controls. Units sample those controls on vsync, so every command is held until a frame boundary has passed.
- Sits between the mouse/card UI logic and the unit renderers.

Parameters:
NUM_UNITS, 4, number of unit instances controlled (index 0 has highest priority)
ELIXIR_MAX, 10, elixir saturation value (must be ≤15)
FRAMES_PER_ELIXIR, 60, frame_tick count per elixir point (must be ≤127)
ELIXIR_INIT, 5, elixir value after reset

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-Clk pulse per frame (vsync rising edge already synchronised to Clk)
game_over  in  1  level; freezes elixir and blocks new selections
select_req  in  NUM_UNITS  card clicked this cycle, one bit per unit
place_click  in  1  one-Clk pulse, mouse button released
place_valid  in  1  mouse is inside the player's deploy half (sampled with place_click)
cancel  in  1  one-Clk pulse, right-click abort
unit_cost  in  4*NUM_UNITS  per-unit cost; unit i occupies bits [4i+3:4i]
unit_infield  in  NUM_UNITS  unit i is deployed and alive
unit_dead  in  NUM_UNITS  unit i has hp==0
idle_o  out  NUM_UNITS  unit reset/recycle command
instate_o  out  NUM_UNITS  unit follows the mouse
deploy_o  out  NUM_UNITS  unit latches the mouse position and deploys
elixir  out  4  current elixir
sel_idx  out  2  index of the armed unit
busy  out  1  FSM is not in S_IDLE

Behaviour:
- Reset values:
  - state S_IDLE; elixir=ELIXIR_INIT; frame count=0; sel_idx=0; instate_o=0; deploy_o=0.
  - idle_o = all ones; it releases after the first frame_tick following reset deassertion, so every unit samples idle.
- Elixir:
  - A 7-bit frame counter increments on frame_tick; at FRAMES_PER_ELIXIR-1 it wraps to 0 and elixir increments.
  - At ELIXIR_MAX the counter holds at 0 and elixir does not increment.
  - game_over freezes both counter and elixir.
  - Charge and increment in the same cycle: result = min(elixir - cost + 1, ELIXIR_MAX).
  - Elixir never underflows, because charging requires elixir ≥ cost.
- S_IDLE:
  - Eligible unit: select_req[i]=1, unit_infield[i]=0, idle_o[i]=0, elixir ≥ cost[i], game_over=0.
  - Lowest eligible index wins and is latched into sel_idx; transition to S_ARMED.
  - Non-eligible requests are ignored silently.
- S_ARMED:
  - instate_o[sel_idx]=1 combinationally from registered state; all other bits are 0.
  - cancel → S_IDLE, no charge.
  - place_click with place_valid=1 → S_DEPLOY; elixir is charged on this transition.
  - place_click with place_valid=0 is ignored.
  - cancel and place_click in the same cycle: cancel wins.
  - game_over → S_IDLE.
  - select_req is ignored in this state.
- S_DEPLOY:
  - deploy_o[sel_idx]=1 and instate_o is dropped.
  - deploy_o holds until the second frame_tick seen in this state, so the unit gets one vsync edge with deploy high; then → S_IDLE.
  - Inputs are ignored during S_DEPLOY.
- Recycle:
  - Independent of the FSM: a rising edge of unit_dead[i] while idle_o[i]=0 sets idle_o[i].
  - idle_o[i] clears after two frame_ticks, ensuring one full vsync sample.
  - While idle_o[i]=1, unit i is not eligible for selection.
- Ordering: deploy_o and idle_o never both high for one unit, because selection excludes units with idle_o set.
- Reset asserted mid-operation: all state returns to reset values next Clk, including any deploy in progress; no elixir refund logic is needed.
- All outputs are registered except instate_o and deploy_o, which are decoded from registered state/sel_idx.

Test Plan:
- Reset, then 60 frame_ticks → elixir 5→6; after 300 more ticks elixir saturates at 10 and holds through 60 further ticks.
- elixir=5, costs {3,4,2,6}, select_req=4'b1010 → sel_idx=1, instate_o=0010; place_click+place_valid → deploy_o=0010 held across exactly 2 frame_ticks, elixir=1.
- elixir=2, select_req[3] with cost 6 → stays S_IDLE, outputs 0; select_req[2] with cost 2 → arms, cancel → S_IDLE, elixir still 2.
- Armed unit 0, place_click with place_valid=0 → still S_ARMED; same-cycle cancel+place_click → S_IDLE, no charge.
- Charge cost 3 in the cycle the counter wraps with elixir=4 → elixir=2.
- unit_dead[1] rises → idle_o[1]=1 for 2 frame_ticks then 0; select_req[1] during that window is ignored. Reset mid-S_DEPLOY → deploy_o=0 next cycle and elixir=5.
